// File: rtl/queue_dispatcher_pkg.sv
// queue_dispatcher_pkg: shared MemorEDF types for the queue dispatcher (FSM state, queue-id width).
package queue_dispatcher_pkg;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
  function automatic int qid_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/queue_dispatcher_if.sv
// queue_dispatcher_if: scheduler, queue-head, downstream and counter signals of the dispatcher.
interface queue_dispatcher_if import queue_dispatcher_pkg::*; #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_WIDTH = 64,
  parameter int COUNTER_WIDTH = 16
);
  localparam int QW = qid_width(NUMBER_OF_QUEUES);
  logic sched_valid;
  logic [QW-1:0] sched_selection;
  logic [NUMBER_OF_QUEUES-1:0] empty;
  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0] queue_data;
  logic [NUMBER_OF_QUEUES-1:0] pop;
  logic m_valid;
  logic m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [QW-1:0] m_queue;
  logic clear_counts;
  logic [NUMBER_OF_QUEUES-1:0][COUNTER_WIDTH-1:0] served_count;
  modport master (
    input sched_valid, sched_selection, empty, queue_data, m_ready, clear_counts,
    output pop, m_valid, m_data, m_queue, served_count
  );
  modport slave (
    output sched_valid, sched_selection, empty, queue_data, m_ready, clear_counts,
    input pop, m_valid, m_data, m_queue, served_count
  );
endinterface

// File: rtl/saturating_counter.sv
// saturating_counter: clearable up-counter that sticks at its maximum value.
module saturating_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             increment,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clock)
    if (reset || clear) count <= '0;
    else if (increment && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/queue_dispatcher.sv
// queue_dispatcher: pops the scheduler-selected FWFT queue into a one-word output register with per-queue served counters.
module queue_dispatcher import queue_dispatcher_pkg::*; #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_WIDTH = 64,
  parameter int COUNTER_WIDTH = 16
) (
  input logic clock,
  input logic reset,
  queue_dispatcher_if.master bus
);
  localparam int QW = qid_width(NUMBER_OF_QUEUES);
  localparam logic [QW:0] NQ = (QW+1)'(NUMBER_OF_QUEUES);
  state_t state;
  logic accept;
  logic fire;
  logic hs;
  always_comb begin
    bus.m_valid = state == HOLD;
    accept = bus.sched_valid && ({1'b0, bus.sched_selection} < NQ) && !bus.empty[bus.sched_selection];
    fire = accept && (state == IDLE || bus.m_ready) && !reset;
    hs = bus.m_valid && bus.m_ready;
    bus.pop = fire ? NUMBER_OF_QUEUES'(1) << bus.sched_selection : '0;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      bus.m_data <= '0;
      bus.m_queue <= '0;
    end else if (fire) begin
      state <= HOLD;
      bus.m_data <= bus.queue_data[bus.sched_selection];
      bus.m_queue <= bus.sched_selection;
    end else if (bus.m_ready) state <= IDLE;
  // Counting follows the registered m_queue, so a word is credited when it leaves, not when popped.
  for (genvar i = 0; i < NUMBER_OF_QUEUES; i++) begin : g_cnt
    saturating_counter #(.WIDTH(COUNTER_WIDTH)) u_cnt (
      .clock(clock),
      .reset(reset),
      .clear(bus.clear_counts),
      .increment(hs && bus.m_queue == QW'(i)),
      .count(bus.served_count[i])
    );
  end
endmodule

// File: tb/tb_queue_dispatcher.sv
// tb_queue_dispatcher: scoreboard bench with FIFO-level reference model; second instance covers out-of-range ids and saturation.
module tb_queue_dispatcher;
  logic clock = 0;
  always #5 clock = ~clock;
  logic a_reset = 1;
  logic b_reset = 1;
  queue_dispatcher_if #(.NUMBER_OF_QUEUES(4), .DATA_WIDTH(64), .COUNTER_WIDTH(16)) a();
  queue_dispatcher_if #(.NUMBER_OF_QUEUES(3), .DATA_WIDTH(64), .COUNTER_WIDTH(2)) b();
  queue_dispatcher #(.NUMBER_OF_QUEUES(4), .DATA_WIDTH(64), .COUNTER_WIDTH(16)) dut_a (
    .clock(clock), .reset(a_reset), .bus(a));
  queue_dispatcher #(.NUMBER_OF_QUEUES(3), .DATA_WIDTH(64), .COUNTER_WIDTH(2)) dut_b (
    .clock(clock), .reset(b_reset), .bus(b));
  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] fq[4][$];
  int exp_sel[$];
  logic [63:0] exp_dat[$];
  int cnt[4] = '{default: 0};
  logic held = 0;
  bit auto_fill = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // One cycle on instance A: drive, check pop and m_valid, then advance the model.
  task automatic step(input logic rst, input logic sv, input int sel, input logic mr, input logic clr);
    logic exp_pop;
    logic [3:0] ep;
    int k;
    @(posedge clock);
    #1;
    if (auto_fill && $urandom_range(0, 2) == 0) begin
      k = $urandom_range(0, 3);
      if (fq[k].size() < 4) fq[k].push_back({$urandom, $urandom});
    end
    a_reset = rst;
    a.sched_valid = sv;
    a.sched_selection = 2'(sel);
    a.m_ready = mr;
    a.clear_counts = clr;
    for (int i = 0; i < 4; i++) begin
      a.empty[i] = fq[i].size() == 0;
      a.queue_data[i] = fq[i].size() == 0 ? 64'h0 : fq[i][0];
    end
    exp_pop = !rst && sv && sel < 4 && fq[sel].size() > 0 && (!held || mr);
    ep = exp_pop ? 4'(1 << sel) : 4'b0;
    #1;
    check("pop", 64'(a.pop), 64'(ep));
    check("m_valid", 64'(a.m_valid), 64'(held));
    if (rst) held = 0;
    else begin
      if (held && mr) held = 0;
      if (exp_pop) begin
        exp_sel.push_back(sel);
        exp_dat.push_back(fq[sel].pop_front());
        held = 1;
      end
    end
  endtask
  task automatic bdrive(input logic sv, input int sel, input logic mr, input logic clr);
    @(posedge clock);
    #1;
    b_reset = 0;
    b.sched_valid = sv;
    b.sched_selection = 2'(sel);
    b.m_ready = mr;
    b.clear_counts = clr;
    #1;
  endtask
  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) check("served_count", 64'(a.served_count[i]), 64'(cnt[i]));
    if (a_reset) begin
      cnt = '{default: 0};
      exp_sel.delete();
      exp_dat.delete();
    end else begin
      if (a.m_valid && a.m_ready) begin
        if (exp_dat.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL handshake: unexpected word %h expected none", a.m_data);
        end else begin
          int s;
          logic [63:0] d;
          s = exp_sel.pop_front();
          d = exp_dat.pop_front();
          check("m_data", a.m_data, d);
          check("m_queue", 64'(a.m_queue), 64'(s));
          if (!a.clear_counts && cnt[s] < 65535) cnt[s]++;
        end
      end
      if (a.clear_counts) cnt = '{default: 0};
    end
  end
  initial begin
    a.sched_valid = 0; a.sched_selection = 0; a.empty = '1; a.queue_data = '0;
    a.m_ready = 0; a.clear_counts = 0;
    b.sched_valid = 0; b.sched_selection = 0; b.empty = 3'b101; b.queue_data = '0;
    b.m_ready = 0; b.clear_counts = 0;
    b.queue_data[1] = 64'hB0B;
    fq[2].push_back(64'hA5);
    repeat (3) step(1, 1, 2, 0, 0);
    step(0, 0, 2, 0, 0);
    check("reset m_data", a.m_data, 64'h0);
    check("reset m_queue", 64'(a.m_queue), 64'd0);
    step(0, 1, 2, 1, 0);
    step(0, 0, 2, 1, 0);
    check("first m_data", a.m_data, 64'hA5);
    check("first m_queue", 64'(a.m_queue), 64'd2);
    step(0, 0, 0, 1, 0);
    fq[1].push_back(64'h1111_2222_3333_4444);
    fq[1].push_back(64'h5555_6666_7777_8888);
    step(0, 1, 1, 0, 0);
    repeat (5) begin
      step(0, 1, 1, 0, 0);
      check("bp m_data", a.m_data, 64'h1111_2222_3333_4444);
      check("bp m_queue", 64'(a.m_queue), 64'd1);
    end
    step(0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    check("bp next m_data", a.m_data, 64'h5555_6666_7777_8888);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      fq[0].push_back({$urandom, $urandom});
      fq[1].push_back({$urandom, $urandom});
    end
    for (int i = 0; i < 8; i++) step(0, 1, i % 2, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check("stream count0", 64'(a.served_count[0]), 64'd4);
    check("stream count1", 64'(a.served_count[1]), 64'd4);
    step(0, 1, 3, 1, 0);
    step(0, 0, 0, 1, 0);
    fq[0].push_back(64'hC0FFEE);
    fq[0].push_back(64'hBEEF);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst hold m_valid", 64'(a.m_valid), 64'd0);
    for (int i = 0; i < 4; i++) check("rst hold count", 64'(a.served_count[i]), 64'd0);
    for (int i = 0; i < 4; i++) fq[i].delete();
    auto_fill = 1;
    repeat (1500)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
           $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
    auto_fill = 0;
    repeat (8) step(0, 0, 0, 1, 0);
    check("leftover words", 64'(exp_dat.size()), 64'd0);
    bdrive(1, 3, 1, 0);
    check("b out-of-range pop", 64'(b.pop), 64'd0);
    bdrive(0, 0, 1, 0);
    check("b out-of-range m_valid", 64'(b.m_valid), 64'd0);
    for (int i = 0; i < 7; i++) begin
      bdrive(i < 5, 1, 1, 0);
      if (i == 0) check("b pop", 64'(b.pop), 64'b010);
    end
    bdrive(0, 1, 1, 0);
    check("b saturated", 64'(b.served_count[1]), 64'd3);
    check("b idle m_valid", 64'(b.m_valid), 64'd0);
    bdrive(1, 1, 1, 0);
    check("b pop again", 64'(b.pop), 64'b010);
    bdrive(0, 1, 1, 1);
    check("b hold m_valid", 64'(b.m_valid), 64'd1);
    check("b m_data", b.m_data, 64'hB0B);
    check("b m_queue", 64'(b.m_queue), 64'd1);
    bdrive(0, 1, 1, 0);
    check("b cleared", 64'(b.served_count[1]), 64'd0);
    check("b after m_valid", 64'(b.m_valid), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/queue_dispatcher.md
QUEUE_DISPATCHER -- requirements
Module: queue_dispatcher

Interface
REQ-001 SHALL have parameter NUMBER_OF_QUEUES, default 4, number of input queues (>=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, packet word width.
REQ-003 SHALL have parameter COUNTER_WIDTH, default 16, per-queue served-counter width.
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sched_valid  input  1  scheduler has a non-empty queue selected.
REQ-007 SHALL have port sched_selection  input  clog2(NUMBER_OF_QUEUES)  scheduler-chosen queue id.
REQ-008 SHALL have port empty  input  NUMBER_OF_QUEUES  per-queue empty flag.
REQ-009 SHALL have port queue_data  input  NUMBER_OF_QUEUES x DATA_WIDTH  head word of each first-word-fall-through queue.
REQ-010 SHALL have port pop  output  NUMBER_OF_QUEUES  one-hot-or-zero dequeue strobe.
REQ-011 SHALL have port m_valid  output  1  downstream word valid.
REQ-012 SHALL have port m_ready  input  1  downstream accepts word.
REQ-013 SHALL have port m_data  output  DATA_WIDTH  dispatched word.
REQ-014 SHALL have port m_queue  output  clog2(NUMBER_OF_QUEUES)  source queue id of m_data.
REQ-015 SHALL have port clear_counts  input  1  synchronous clear of all served counters.
REQ-016 SHALL have port served_count  output  NUMBER_OF_QUEUES x COUNTER_WIDTH  words dispatched per queue.

Function
REQ-017 SHALL implement a two-state FSM: IDLE (output register empty) and HOLD (output register full, m_valid=1).
REQ-018 SHALL define "accept" as: sched_valid=1, sched_selection<NUMBER_OF_QUEUES, and empty[sched_selection]=0.
REQ-019 SHALL define "slot free" as: state IDLE, or state HOLD with m_ready=1.
REQ-020 SHALL assert pop[sched_selection] combinationally for exactly the cycles where accept and slot free both hold; all other pop bits 0.
REQ-021 SHALL, on a pop cycle, register queue_data[sched_selection] into m_data and sched_selection into m_queue, and enter or remain in HOLD (latency: accept at edge t gives m_valid=1 after edge t).
REQ-022 SHALL, in HOLD with m_ready=1 and no pop, return to IDLE with m_valid=0.
REQ-023 SHALL keep m_data and m_queue stable while m_valid=1 and m_ready=0.
REQ-024 SHALL sustain one word per cycle when sched_valid and m_ready are continuously high.
REQ-025 SHALL ignore sched_valid when empty[sched_selection]=1 or sched_selection is out of range (no pop, no state change).
REQ-026 SHALL increment served_count[m_queue] by 1 on each handshake (m_valid & m_ready), saturating at 2^COUNTER_WIDTH-1.
REQ-027 SHALL give clear_counts priority over a same-cycle increment (all counters become 0).

Reset
REQ-028 SHALL, on reset, set state IDLE, m_valid=0, m_data=0, m_queue=0, all served_count=0; pop SHALL be 0 during reset cycles.
REQ-029 SHALL discard a word held in HOLD when reset asserts mid-operation; it is not counted.

Structure
REQ-030 SHALL place the FSM state enum (IDLE, HOLD) and a queue-id width constant function in the shared MemorEDF package.
REQ-031 SHALL implement served counters in one sub-module, saturating_counter (parameter WIDTH; ports clock, reset, clear, increment, count), instantiated NUMBER_OF_QUEUES times.

Verification
REQ-032 SHALL test: after reset, sched_valid=1, sel=2, empty=4'b1011, queue_data[2]=64'hA5 -> pop=4'b0100 one cycle, next cycle m_valid=1, m_data=64'hA5, m_queue=2.
REQ-033 SHALL test backpressure: m_ready=0 for 5 cycles while sched_valid=1 -> pop stays 0, m_data/m_queue unchanged, m_valid=1 throughout.
REQ-034 SHALL test streaming: m_ready=1, sched_valid=1, sel alternating 0,1 for 8 cycles -> 8 pops, 8 handshakes, served_count[0]=4, served_count[1]=4.
REQ-035 SHALL test inconsistency: sched_valid=1, sel=3, empty[3]=1 -> pop=0, m_valid stays 0.
REQ-036 SHALL test saturation/clear: COUNTER_WIDTH=2, 5 handshakes on queue 1 -> served_count[1]=3; clear_counts with a same-cycle handshake -> 0.
REQ-037 SHALL test reset in HOLD: m_valid=1, m_ready=0, reset pulse -> m_valid=0, counters 0, no pop during reset.
